// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types: forwarding select encodings, hazard FSM states, forward-select helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    // The younger producer (EX/MEM) must win over MEM/WB; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_exmem,
        input logic       we_exmem,
        input logic [4:0] rd_memwb,
        input logic       we_memwb
    );
        if (we_exmem && (rd_exmem != 5'd0) && (rd_exmem == rs)) begin
            return FWD_EXMEM;
        end
        if (we_memwb && (rd_memwb != 5'd0) && (rd_memwb == rs)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// ALU operand forwarding selects for the instruction in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none.
module forwarding_unit
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] rs1_IDEX,
    input  logic [4:0] rs2_IDEX,
    input  logic [4:0] rd_EXMEM,
    input  logic       RegWrite_EXMEM,
    input  logic [4:0] rd_MEMWB,
    input  logic       RegWrite_MEMWB,
    output logic [1:0] forwardA,
    output logic [1:0] forwardB
);

    assign forwardA = fwd_select(rs1_IDEX, rd_EXMEM, RegWrite_EXMEM, rd_MEMWB, RegWrite_MEMWB);
    assign forwardB = fwd_select(rs2_IDEX, rd_EXMEM, RegWrite_EXMEM, rd_MEMWB, RegWrite_MEMWB);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall / taken-branch redirect sequencer with ALU forwarding and saturating event counters.
// Latency: control outputs combinational (same cycle); FSM, wait count and counters update on clk.
// Backpressure: originates stalls (pc_write/ifid_write low) toward PC and IF/ID; accepts none itself.
module hazard_ctrl_unit
    import riscv_pipe_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_IFID,
    input  logic [4:0]       rs2_IFID,
    input  logic [4:0]       rs1_IDEX,
    input  logic [4:0]       rs2_IDEX,
    input  logic [4:0]       rd_IDEX,
    input  logic             memRead_IDEX,
    input  logic [4:0]       rd_EXMEM,
    input  logic             RegWrite_EXMEM,
    input  logic [4:0]       rd_MEMWB,
    input  logic             RegWrite_MEMWB,
    input  logic             branch_EXMEM,
    input  logic             zero_EXMEM,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             flush_EXMEM,
    output logic             pc_sel,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WAIT_W    = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LU_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_nxt;
    logic              taken;
    logic              lu_hit;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    assign taken  = branch_EXMEM & zero_EXMEM;
    assign lu_hit = memRead_IDEX & (rd_IDEX != 5'd0)
                  & ((rd_IDEX == rs1_IFID) | (rd_IDEX == rs2_IFID));

    forwarding_unit u_fwd (
        .rs1_IDEX       (rs1_IDEX),
        .rs2_IDEX       (rs2_IDEX),
        .rd_EXMEM       (rd_EXMEM),
        .RegWrite_EXMEM (RegWrite_EXMEM),
        .rd_MEMWB       (rd_MEMWB),
        .RegWrite_MEMWB (RegWrite_MEMWB),
        .forwardA       (fwd_a),
        .forwardB       (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            wait_q <= '0;
        end else begin
            state  <= state_nxt;
            wait_q <= wait_nxt;
        end
    end

    // A taken branch squashes the stalled instruction, so it cancels any remaining stall cycles.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_q;
        case (state)
            RUN: begin
                if (!taken && lu_hit && (LU_STALL_CYCLES > 1)) begin
                    state_nxt = STALL;
                    wait_nxt  = WAIT_LOAD;
                end
            end
            STALL: begin
                if (taken || (wait_q == WAIT_W'(1))) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt  = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        flush_EXMEM = 1'b0;
        pc_sel      = 1'b0;
        forwardA    = FWD_REG;
        forwardB    = FWD_REG;
        if (rst_n) begin
            forwardA = fwd_a;
            forwardB = fwd_b;
            if (taken) begin
                pc_sel      = 1'b1;
                flush_IFID  = 1'b1;
                flush_IDEX  = 1'b1;
                flush_EXMEM = 1'b1;
            end else if (lu_hit || (state == STALL)) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            flush_cnt <= '0;
        end else if (taken && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    a_no_stall_with_redirect: assert property (@(posedge clk) disable iff (!rst_n)
        !(pc_sel && !pc_write));

endmodule
